legv8_pc_sequencer: RTL and testbench

//  Multi-cycle sequencer for the LEGv8 program counter. Fetches each instruction over an

---
 rtl/legv8_pc_sequencer_pkg.sv | 74 +++++++
 rtl/legv8_pc_sequencer_if.sv | 55 +++++
 rtl/legv8_pc_sequencer_cond_eval.sv | 53 +++++
 rtl/legv8_pc_sequencer.sv | 177 +++++++++++++++++
 tb/tb_legv8_pc_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// legv8_seq_pkg
//   Shared definitions for the LEGv8 PC sequencer and its neighbours:
//   - PC select (PS) encodings driven to the PC register block
//   - br_kind codes produced by the decoder
//   - sequencer state encoding
//   - B.cond condition-code field values
//   - resolve_ps(): maps a branch kind plus flag results to a PS code
// ----------------------------------------------------------------------------
package legv8_seq_pkg;

    // PC select codes
    localparam logic [1:0] PS_HOLD = 2'b00;  // PC keeps its value
    localparam logic [1:0] PS_INC  = 2'b01;  // PC <= PC + 4
    localparam logic [1:0] PS_REG  = 2'b10;  // PC <= register operand (BR)
    localparam logic [1:0] PS_BR   = 2'b11;  // PC <= PC + 4 + (offset << 2)

    // Branch kinds from the decoder; 6 and 7 are reserved and behave as "none"
    localparam logic [2:0] BK_NONE  = 3'd0;
    localparam logic [2:0] BK_B     = 3'd1;
    localparam logic [2:0] BK_CBZ   = 3'd2;
    localparam logic [2:0] BK_CBNZ  = 3'd3;
    localparam logic [2:0] BK_BR    = 3'd4;
    localparam logic [2:0] BK_BCOND = 3'd5;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALT   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    // B.cond condition field values
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100;
    localparam logic [3:0] CC_PL = 4'b0101;
    localparam logic [3:0] CC_VS = 4'b0110;
    localparam logic [3:0] CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000;
    localparam logic [3:0] CC_LS = 4'b1001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;
    localparam logic [3:0] CC_AL = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    // Branch resolution. Never returns PS_HOLD: every retired instruction
    // moves the PC somewhere.
    function automatic logic [1:0] resolve_ps(
        input logic [2:0] kind,
        input logic       zero,
        input logic       cond_true
    );
        logic [1:0] ps;
        ps = PS_INC;
        case (kind)
            BK_B:     ps = PS_BR;
            BK_CBZ:   ps = zero ? PS_BR : PS_INC;
            BK_CBNZ:  ps = zero ? PS_INC : PS_BR;
            BK_BR:    ps = PS_REG;
            BK_BCOND: ps = cond_true ? PS_BR : PS_INC;
            default:  ps = PS_INC;
        endcase
        return ps;
    endfunction

endpackage

// File: rtl/legv8_pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// legv8_pc_sequencer_if
//   Fetch handshake and execute-result bundle between the PC sequencer
//   (master) and the instruction memory / datapath (slave).
//
//   Handshake: imem_req is raised by the sequencer and held high until the
//   cycle in which imem_ready is seen high; that cycle is the transfer, and
//   the sequencer pulses ir_load in the same cycle. imem_ready is only
//   meaningful while imem_req is high. exec_done is a single-cycle strobe
//   that qualifies br_kind/cond/zero/nzcv in the same cycle.
//
//   Signals:
//     imem_req   master->slave  fetch request
//     imem_ready slave->master  fetch data valid this cycle
//     ir_load    master->slave  load instruction register
//     exec_done  slave->master  datapath finished the loaded instruction
//     br_kind    slave->master  branch kind (see legv8_seq_pkg)
//     cond       slave->master  B.cond condition field
//     zero       slave->master  ALU zero result
//     nzcv       slave->master  status flags {N,Z,C,V}
// ----------------------------------------------------------------------------
interface legv8_pc_sequencer_if;

    logic       imem_req;
    logic       imem_ready;
    logic       ir_load;
    logic       exec_done;
    logic [2:0] br_kind;
    logic [3:0] cond;
    logic       zero;
    logic [3:0] nzcv;

    modport master (
        output imem_req,
        output ir_load,
        input  imem_ready,
        input  exec_done,
        input  br_kind,
        input  cond,
        input  zero,
        input  nzcv
    );

    modport slave (
        input  imem_req,
        input  ir_load,
        output imem_ready,
        output exec_done,
        output br_kind,
        output cond,
        output zero,
        output nzcv
    );

endinterface

// File: rtl/legv8_pc_sequencer_cond_eval.sv
// ----------------------------------------------------------------------------
// legv8_cond_eval
//   Combinational evaluation of a LEGv8 B.cond condition against the NZCV
//   flags. Also used by the decode stage, so it has no clock or state.
//
//   Ports:
//     i_cond   in  4  condition field
//     i_nzcv   in  4  flags {N,Z,C,V}
//     o_taken  out 1  condition holds
// ----------------------------------------------------------------------------
module legv8_cond_eval
    import legv8_seq_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_taken
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = i_nzcv[3];
    assign w_z = i_nzcv[2];
    assign w_c = i_nzcv[1];
    assign w_v = i_nzcv[0];

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            CC_EQ:   o_taken = w_z;
            CC_NE:   o_taken = !w_z;
            CC_CS:   o_taken = w_c;
            CC_CC:   o_taken = !w_c;
            CC_MI:   o_taken = w_n;
            CC_PL:   o_taken = !w_n;
            CC_VS:   o_taken = w_v;
            CC_VC:   o_taken = !w_v;
            CC_HI:   o_taken = w_c && !w_z;
            CC_LS:   o_taken = !(w_c && !w_z);
            CC_GE:   o_taken = (w_n == w_v);
            CC_LT:   o_taken = (w_n != w_v);
            CC_GT:   o_taken = !w_z && (w_n == w_v);
            CC_LE:   o_taken = !(!w_z && (w_n == w_v));
            // AL and NV both mean "always" on LEGv8
            CC_AL:   o_taken = 1'b1;
            CC_NV:   o_taken = 1'b1;
            default: o_taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/legv8_pc_sequencer.sv
// ----------------------------------------------------------------------------
// legv8_pc_sequencer
//   Multi-cycle sequencer for the LEGv8 program counter. Fetches one
//   instruction over the imem handshake, waits for the datapath to finish
//   it, resolves the branch outcome and drives PS for exactly one cycle
//   (UPDATE). It is the only source of PS.
//
//   Parameters:
//     TIMEOUT_CYCLES  max FETCH cycles without imem_ready before fault
//     TO_W            width of the fetch wait counter
//     CNT_W           width of the retired-instruction counter
//
//   Ports:
//     clock         in   rising-edge clock
//     reset         in   synchronous, active-low reset
//     start         in   begin/resume (honoured in IDLE and HALT only)
//     halt_req      in   stop after current instruction retires
//     bus           if   fetch handshake and execute results (master side)
//     PS            out  PC select, non-zero only in UPDATE
//     branch_taken  out  pulse in UPDATE when PS is REG or BR
//     instr_count   out  retired instructions, wraps
//     busy          out  high in FETCH, EXEC, UPDATE
//     halted        out  high in HALT
//     fault         out  high in ERR
//     dbg_state     out  current state encoding (state_t)
// ----------------------------------------------------------------------------
module legv8_pc_sequencer
    import legv8_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TO_W           = 4,
    parameter int CNT_W          = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt_req,
    legv8_pc_sequencer_if.master  bus,
    output logic [1:0]            PS,
    output logic                  branch_taken,
    output logic [CNT_W-1:0]      instr_count,
    output logic                  busy,
    output logic                  halted,
    output logic                  fault,
    output logic [2:0]            dbg_state
);

    // The wait counter value seen in the last allowed FETCH cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [TO_W-1:0]  r_wait;
    logic [1:0]       r_next_ps;
    logic             r_halt;
    logic [CNT_W-1:0] r_count;
    logic             w_cond_true;
    logic             w_busy;

    legv8_cond_eval u_cond_eval (
        .i_cond  (bus.cond),
        .i_nzcv  (bus.nzcv),
        .o_taken (w_cond_true)
    );

    assign w_busy = (r_state == ST_FETCH) || (r_state == ST_EXEC) ||
                    (r_state == ST_UPDATE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                // Ready on the last allowed cycle still wins over timeout.
                if (bus.imem_ready)      w_next_state = ST_EXEC;
                else if (r_wait == TO_LAST) w_next_state = ST_ERR;
            end
            ST_EXEC: begin
                if (bus.exec_done) w_next_state = ST_UPDATE;
            end
            ST_UPDATE: begin
                // halt_req in this very cycle counts as well as the latch.
                if (r_halt || halt_req) w_next_state = ST_HALT;
                else                    w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                if (start) w_next_state = ST_FETCH;
            end
            ST_ERR: begin
                w_next_state = ST_ERR;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            r_next_ps <= PS_HOLD;
            r_halt    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next_state;

            // Counts FETCH cycles that ended without ready; cleared otherwise.
            if ((r_state == ST_FETCH) && (w_next_state == ST_FETCH)) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end

            // Flags are only valid alongside exec_done, so capture them there.
            if ((r_state == ST_EXEC) && bus.exec_done) begin
                r_next_ps <= resolve_ps(bus.br_kind, bus.zero, w_cond_true);
            end

            // Halt requests are remembered while an instruction is in flight
            // and forgotten once HALT is reached.
            if (w_next_state == ST_HALT) begin
                r_halt <= 1'b0;
            end else if (halt_req && w_busy) begin
                r_halt <= 1'b1;
            end

            if (r_state == ST_UPDATE) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (Moore, except ir_load which follows imem_ready)
    // ------------------------------------------------------------------
    always_comb begin
        PS           = PS_HOLD;
        branch_taken = 1'b0;
        bus.imem_req = 1'b0;
        bus.ir_load  = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_load  = bus.imem_ready;
            end
            ST_UPDATE: begin
                PS           = r_next_ps;
                branch_taken = r_next_ps[1];
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_ERR: begin
                fault = 1'b1;
            end
            default: begin
                PS = PS_HOLD;
            end
        endcase
    end

    assign busy        = w_busy;
    assign instr_count = r_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_legv8_pc_sequencer.sv
module tb_legv8_pc_sequencer;
  import legv8_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  logic start;
  logic halt_req;
  logic [1:0]  PS;
  logic        branch_taken;
  logic [31:0] instr_count;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [2:0]  dbg_state;

  legv8_pc_sequencer_if bus();

  legv8_pc_sequencer #(
    .TIMEOUT_CYCLES(15),
    .TO_W(4),
    .CNT_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .halt_req(halt_req),
    .bus(bus),
    .PS(PS),
    .branch_taken(branch_taken),
    .instr_count(instr_count),
    .busy(busy),
    .halted(halted),
    .fault(fault),
    .dbg_state(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  // entry = {ps[1:0], branch_taken, instr_count during UPDATE[31:0]}
  logic [34:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_irload = 0;
  logic [31:0] exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (bus.ir_load === 1'b1) n_irload++;
    if (reset === 1'b1 && PS !== 2'b00) begin
      logic [34:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ps: got PS=%b with nothing expected (t=%0t)", PS, $time);
      end else begin
        e = exp_q.pop_front();
        if ({PS, branch_taken, instr_count} !== e) begin
          n_err++;
          $display("FAIL update: got PS=%b taken=%b count=%0d expected PS=%b taken=%b count=%0d (t=%0t)",
                   PS, branch_taken, instr_count, e[34:33], e[32], e[31:0], $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_count = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Starts in FETCH; ends one cycle after UPDATE (FETCH or HALT).
  task automatic fetch_exec(input int dly, input logic [2:0] kind, input logic [3:0] cnd,
                            input logic z, input logic [3:0] f, input logic [1:0] exp_ps,
                            input logic halt_mid);
    int irl0;
    irl0 = n_irload;
    for (int i = 0; i < dly; i++) tick();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    check("ir_load_pulse", n_irload - irl0, 1);
    if (halt_mid) halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    bus.br_kind = kind;
    bus.cond = cnd;
    bus.zero = z;
    bus.nzcv = f;
    bus.exec_done = 1'b1;
    exp_q.push_back({exp_ps, exp_ps[1], exp_count});
    exp_count = exp_count + 1;
    tick();
    // Flags change during UPDATE; PS must not follow them.
    bus.exec_done = 1'b0;
    bus.br_kind = ~kind;
    bus.cond = ~cnd;
    bus.zero = ~z;
    bus.nzcv = ~f;
    tick();
    check("instr_count", instr_count, exp_count);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    start = 1'b0;
    halt_req = 1'b0;
    bus.imem_ready = 1'b0;
    bus.exec_done = 1'b0;
    bus.br_kind = 3'd0;
    bus.cond = 4'd0;
    bus.zero = 1'b0;
    bus.nzcv = 4'd0;

    // reset state
    do_reset();
    check("rst_ps", PS, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_count", instr_count, 0);
    check("rst_taken", branch_taken, 0);

    // 1: plain instruction, ready after 2 cycles
    do_start();
    check("fetch_req", bus.imem_req, 1);
    check("fetch_busy", busy, 1);
    fetch_exec(2, BK_NONE, 4'd0, 1'b0, 4'd0, PS_INC, 1'b0);

    // 2: CBZ / CBNZ
    fetch_exec(0, BK_CBZ,  4'd0, 1'b1, 4'd0, PS_BR,  1'b0);
    fetch_exec(1, BK_CBZ,  4'd0, 1'b0, 4'd0, PS_INC, 1'b0);
    fetch_exec(0, BK_CBNZ, 4'd0, 1'b0, 4'd0, PS_BR,  1'b0);
    fetch_exec(0, BK_CBNZ, 4'd0, 1'b1, 4'd0, PS_INC, 1'b0);

    // 3: B.cond, BR, B, reserved kinds
    fetch_exec(0, BK_BCOND, CC_LT, 1'b0, 4'b1000, PS_BR,  1'b0);
    fetch_exec(0, BK_BCOND, CC_LT, 1'b1, 4'b1001, PS_INC, 1'b0);
    fetch_exec(0, BK_BR,    4'd0,  1'b0, 4'd0,    PS_REG, 1'b0);
    fetch_exec(0, BK_BCOND, CC_GT, 1'b0, 4'b0000, PS_BR,  1'b0);
    fetch_exec(0, BK_BCOND, CC_GT, 1'b0, 4'b0100, PS_INC, 1'b0);
    fetch_exec(0, BK_BCOND, CC_HI, 1'b0, 4'b0010, PS_BR,  1'b0);
    fetch_exec(0, BK_BCOND, CC_LS, 1'b0, 4'b0010, PS_INC, 1'b0);
    fetch_exec(0, BK_BCOND, CC_EQ, 1'b0, 4'b0100, PS_BR,  1'b0);
    fetch_exec(0, BK_BCOND, CC_NE, 1'b1, 4'b0100, PS_INC, 1'b0);
    fetch_exec(0, BK_BCOND, CC_NV, 1'b0, 4'b0000, PS_BR,  1'b0);
    fetch_exec(0, BK_BCOND, CC_VC, 1'b0, 4'b0001, PS_INC, 1'b0);
    fetch_exec(0, BK_BCOND, CC_MI, 1'b0, 4'b1000, PS_BR,  1'b0);
    fetch_exec(0, BK_BCOND, CC_GE, 1'b0, 4'b1001, PS_BR,  1'b0);
    fetch_exec(0, BK_B,     4'd0,  1'b0, 4'd0,    PS_BR,  1'b0);
    fetch_exec(0, 3'd6,     4'd0,  1'b1, 4'd0,    PS_INC, 1'b0);
    fetch_exec(0, 3'd7,     CC_AL, 1'b0, 4'd0,    PS_INC, 1'b0);

    // 5: halt request mid-EXEC, then resume
    fetch_exec(1, BK_NONE, 4'd0, 1'b0, 4'd0, PS_INC, 1'b1);
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    check("halt_ps", PS, 2'b00);
    tick();
    check("halt_stays", halted, 1);
    do_start();
    check("resume_busy", busy, 1);
    check("resume_halted", halted, 0);
    fetch_exec(0, BK_NONE, 4'd0, 1'b0, 4'd0, PS_INC, 1'b0);
    check("no_rehalt", busy, 1);

    // 6a: reset while in EXEC
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_count = 0;
    check("rexec_busy", busy, 0);
    check("rexec_ps", PS, 2'b00);
    check("rexec_count", instr_count, 0);
    check("rexec_req", bus.imem_req, 0);
    tick();
    check("rexec_idle_hold", busy, 0);

    // 6b: ready on the 15th wait cycle wins over the timeout
    do_start();
    fetch_exec(14, BK_NONE, 4'd0, 1'b0, 4'd0, PS_INC, 1'b0);
    check("late_ready_fault", fault, 0);

    // 4: imem_ready never arrives
    for (int i = 0; i < 14; i++) tick();
    check("to_not_yet", fault, 0);
    check("to_req_still", bus.imem_req, 1);
    tick();
    check("to_fault", fault, 1);
    check("to_ps", PS, 2'b00);
    check("to_req", bus.imem_req, 0);
    check("to_busy", busy, 0);
    do_start();
    tick();
    check("to_start_ignored", fault, 1);
    check("to_req_after", bus.imem_req, 0);
    do_reset();
    check("to_reset_fault", fault, 0);
    check("to_reset_busy", busy, 0);

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
